// File: rtl/mshr_file.sv
// Line-based miss status holding registers: merges misses per line, issues one fill per line, replays targets in order.
// Latency: fill request visible the cycle after allocation; replay starts the cycle after fill return, one target per cycle.
// Backpressure: req_ready_o drops on flush, full file, full target list, replaying/filling/squashed line; replay holds while rep_ready_i=0.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   flush_i                               pipeline flush
//   req_*                                 miss request from the LSU (valid/ready)
//   mem_req_*                             line fill request to the next level (valid/ready, per-entry id)
//   fill_valid_i, fill_id_i               fill return, always absorbed
//   rep_*                                 replayed targets to the LSU (valid/ready)
//   full_o                                no FREE entry
module mshr_file #(
  parameter int NUM_ENTRIES = 4,
  parameter int MAX_TARGETS = 4,
  parameter int LINE_BYTES  = 16,
  parameter int ROB_ENTRIES = 32,
  parameter int ROB_IDX_W   = $clog2(ROB_ENTRIES),
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int ID_W  = $clog2(NUM_ENTRIES),
  localparam int CNT_W = $clog2(MAX_TARGETS + 1),
  localparam int TI_W  = (MAX_TARGETS > 1) ? $clog2(MAX_TARGETS) : 1,
  localparam int LA_W  = 32 - OFF_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_is_store_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_data_i,
  input  logic [ROB_IDX_W-1:0] req_rob_idx_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [31:0]          mem_req_addr_o,
  output logic [ID_W-1:0]      mem_req_id_o,
  input  logic                 fill_valid_i,
  input  logic [ID_W-1:0]      fill_id_i,
  output logic                 rep_valid_o,
  input  logic                 rep_ready_i,
  output logic                 rep_is_store_o,
  output logic [ROB_IDX_W-1:0] rep_rob_idx_o,
  output logic [OFF_W-1:0]     rep_offset_o,
  output logic [31:0]          rep_data_o,
  output logic                 full_o
);

  typedef enum logic [1:0] {S_FREE, S_WAIT_ISSUE, S_WAIT_FILL, S_REPLAY} state_e;

  state_e           state_q [NUM_ENTRIES];
  state_e           state_d [NUM_ENTRIES];
  logic [CNT_W-1:0] cnt_q   [NUM_ENTRIES];
  logic [CNT_W-1:0] cnt_d   [NUM_ENTRIES];
  logic [TI_W-1:0]  head_q  [NUM_ENTRIES];
  logic [TI_W-1:0]  head_d  [NUM_ENTRIES];
  logic             sq_q    [NUM_ENTRIES];
  logic             sq_d    [NUM_ENTRIES];
  logic [LA_W-1:0]  line_q  [NUM_ENTRIES];

  logic                 tgt_store_q [NUM_ENTRIES][MAX_TARGETS];
  logic [ROB_IDX_W-1:0] tgt_rob_q   [NUM_ENTRIES][MAX_TARGETS];
  logic [OFF_W-1:0]     tgt_off_q   [NUM_ENTRIES][MAX_TARGETS];
  logic [31:0]          tgt_data_q  [NUM_ENTRIES][MAX_TARGETS];

  // Replay stays on one entry while the LSU stalls, even if a lower entry starts replaying.
  logic            rep_lock_q;
  logic [ID_W-1:0] rep_lock_idx_q;

  logic [LA_W-1:0] req_line;
  logic            match_hit, free_hit, issue_hit, rep_hit;
  logic [ID_W-1:0] match_idx, free_idx, issue_idx, rep_low, rep_idx;
  logic            merge_ok, accept, alloc, merge, mem_hs, rep_hs;
  logic [ID_W-1:0] wr_e;
  logic [TI_W-1:0] wr_t;

  assign req_line = req_addr_i[31:OFF_W];

  // Descending scan so the lowest index wins each search.
  always_comb begin
    match_hit = 1'b0; match_idx = '0;
    free_hit  = 1'b0; free_idx  = '0;
    issue_hit = 1'b0; issue_idx = '0;
    rep_hit   = 1'b0; rep_low   = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (state_q[e] != S_FREE && line_q[e] == req_line) begin
        match_hit = 1'b1; match_idx = ID_W'(e);
      end
      if (state_q[e] == S_FREE)       begin free_hit  = 1'b1; free_idx  = ID_W'(e); end
      if (state_q[e] == S_WAIT_ISSUE) begin issue_hit = 1'b1; issue_idx = ID_W'(e); end
      if (state_q[e] == S_REPLAY)     begin rep_hit   = 1'b1; rep_low   = ID_W'(e); end
    end
  end

  // A squashed entry still owns its line until the fill returns, so it accepts no targets.
  assign merge_ok = (state_q[match_idx] == S_WAIT_ISSUE || state_q[match_idx] == S_WAIT_FILL)
                    && !sq_q[match_idx]
                    && (cnt_q[match_idx] < CNT_W'(MAX_TARGETS))
                    && !(fill_valid_i && fill_id_i == match_idx);

  assign req_ready_o = rst_ni && !flush_i && (match_hit ? merge_ok : free_hit);
  assign accept      = req_valid_i && req_ready_o;
  assign alloc       = accept && !match_hit;
  assign merge       = accept && match_hit;

  // Withdrawing the request during flush keeps memory from accepting a line the flush just freed.
  assign mem_req_valid_o = issue_hit && !flush_i;
  assign mem_req_addr_o  = mem_req_valid_o ? {line_q[issue_idx], OFF_W'(0)} : 32'd0;
  assign mem_req_id_o    = mem_req_valid_o ? issue_idx : '0;
  assign mem_hs          = mem_req_valid_o && mem_req_ready_i;

  assign rep_idx        = rep_lock_q ? rep_lock_idx_q : rep_low;
  assign rep_valid_o    = (rep_lock_q || rep_hit) && !flush_i;
  assign rep_hs         = rep_valid_o && rep_ready_i;
  assign rep_is_store_o = rep_valid_o && tgt_store_q[rep_idx][head_q[rep_idx]];
  assign rep_rob_idx_o  = rep_valid_o ? tgt_rob_q[rep_idx][head_q[rep_idx]]  : '0;
  assign rep_offset_o   = rep_valid_o ? tgt_off_q[rep_idx][head_q[rep_idx]]  : '0;
  assign rep_data_o     = rep_valid_o ? tgt_data_q[rep_idx][head_q[rep_idx]] : 32'd0;

  assign full_o = !free_hit;

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      state_d[e] = state_q[e];
      cnt_d[e]   = cnt_q[e];
      head_d[e]  = head_q[e];
      sq_d[e]    = sq_q[e];
      case (state_q[e])
        S_FREE: begin
          if (alloc && free_idx == ID_W'(e)) begin
            state_d[e] = S_WAIT_ISSUE;
            cnt_d[e]   = CNT_W'(1);
            head_d[e]  = '0;
            sq_d[e]    = 1'b0;
          end
        end
        S_WAIT_ISSUE: begin
          if (flush_i) begin
            state_d[e] = S_FREE;
            cnt_d[e]   = '0;
          end else begin
            if (mem_hs && issue_idx == ID_W'(e)) state_d[e] = S_WAIT_FILL;
            if (merge && match_idx == ID_W'(e))  cnt_d[e] = cnt_q[e] + CNT_W'(1);
          end
        end
        S_WAIT_FILL: begin
          if (fill_valid_i && fill_id_i == ID_W'(e)) begin
            // A flush landing with the fill still drops the targets.
            if (sq_q[e] || flush_i) begin
              state_d[e] = S_FREE;
              cnt_d[e]   = '0;
              sq_d[e]    = 1'b0;
            end else begin
              state_d[e] = S_REPLAY;
              head_d[e]  = '0;
            end
          end else if (flush_i) begin
            sq_d[e]  = 1'b1;
            cnt_d[e] = '0;
          end else if (merge && match_idx == ID_W'(e)) begin
            cnt_d[e] = cnt_q[e] + CNT_W'(1);
          end
        end
        S_REPLAY: begin
          if (flush_i) begin
            state_d[e] = S_FREE;
            cnt_d[e]   = '0;
          end else if (rep_hs && rep_idx == ID_W'(e)) begin
            if (head_q[e] == TI_W'(cnt_q[e] - CNT_W'(1))) begin
              state_d[e] = S_FREE;
              cnt_d[e]   = '0;
            end else begin
              head_d[e] = head_q[e] + TI_W'(1);
            end
          end
        end
        default: state_d[e] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        state_q[e] <= S_FREE;
        cnt_q[e]   <= '0;
        head_q[e]  <= '0;
        sq_q[e]    <= 1'b0;
        line_q[e]  <= '0;
      end
      rep_lock_q     <= 1'b0;
      rep_lock_idx_q <= '0;
    end else begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        state_q[e] <= state_d[e];
        cnt_q[e]   <= cnt_d[e];
        head_q[e]  <= head_d[e];
        sq_q[e]    <= sq_d[e];
      end
      if (alloc) line_q[free_idx] <= req_line;
      rep_lock_q     <= rep_valid_o && !rep_ready_i;
      rep_lock_idx_q <= rep_idx;
    end
  end

  assign wr_e = match_hit ? match_idx : free_idx;
  assign wr_t = match_hit ? TI_W'(cnt_q[match_idx]) : '0;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      tgt_store_q[wr_e][wr_t] <= req_is_store_i;
      tgt_rob_q[wr_e][wr_t]   <= req_rob_idx_i;
      tgt_off_q[wr_e][wr_t]   <= req_addr_i[OFF_W-1:0];
      tgt_data_q[wr_e][wr_t]  <= req_data_i;
    end
  end

endmodule

// File: tb/tb_mshr_file.sv
module tb_mshr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, req_valid, req_ready, req_is_store;
  logic [31:0] req_addr, req_data;
  logic [4:0]  req_rob;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_id;
  logic        fill_valid;
  logic [1:0]  fill_id;
  logic        rep_valid, rep_ready, rep_is_store;
  logic [4:0]  rep_rob;
  logic [3:0]  rep_offset;
  logic [31:0] rep_data;
  logic        full;

  int tests = 0;
  int fails = 0;

  mshr_file dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_rob_idx_i(req_rob),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_id_o(mem_req_id),
    .fill_valid_i(fill_valid), .fill_id_i(fill_id),
    .rep_valid_o(rep_valid), .rep_ready_i(rep_ready), .rep_is_store_o(rep_is_store),
    .rep_rob_idx_o(rep_rob), .rep_offset_o(rep_offset), .rep_data_o(rep_data),
    .full_o(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_data = d; req_rob = r;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
    req_addr = '0; req_data = '0; req_rob = '0; mem_req_ready = 1'b0;
    fill_valid = 1'b0; fill_id = '0; rep_ready = 1'b1;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_rep_valid", rep_valid, 0);
    chk("rst_full", full, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", req_ready, 1);

    // 1: single load miss, issue, fill, replay
    tick();
    req(1'b0, 32'h1004, 32'h0, 5'd3); mem_req_ready = 1'b1;
    #1 chk("t1_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1 chk("t1_mem_valid", mem_req_valid, 1);
    chk("t1_mem_addr", mem_req_addr, 32'h1000);
    chk("t1_mem_id", mem_req_id, 0);
    tick();
    #1 chk("t1_mem_done", mem_req_valid, 0);
    fill_valid = 1'b1; fill_id = 2'd0;
    tick();
    fill_valid = 1'b0;
    #1 chk("t1_rep_valid", rep_valid, 1);
    chk("t1_rep_rob", rep_rob, 3);
    chk("t1_rep_off", rep_offset, 4);
    chk("t1_rep_st", rep_is_store, 0);
    tick();
    #1 chk("t1_rep_end", rep_valid, 0);
    chk("t1_full", full, 0);

    // 2: load + merged store, single fill, ordered replay
    req(1'b0, 32'h2000, 32'h0, 5'd1); mem_req_ready = 1'b0;
    tick();
    req(1'b1, 32'h2008, 32'hDEADBEEF, 5'd2); mem_req_ready = 1'b1;
    #1 chk("t2_merge_ready", req_ready, 1);
    chk("t2_mem_addr", mem_req_addr, 32'h2000);
    tick();
    req_valid = 1'b0;
    #1 chk("t2_single_req", mem_req_valid, 0);
    fill_valid = 1'b1; fill_id = 2'd0;
    tick();
    fill_valid = 1'b0;
    #1 chk("t2_rep0_rob", rep_rob, 1);
    chk("t2_rep0_st", rep_is_store, 0);
    chk("t2_rep0_off", rep_offset, 0);
    tick();
    #1 chk("t2_rep1_valid", rep_valid, 1);
    chk("t2_rep1_rob", rep_rob, 2);
    chk("t2_rep1_st", rep_is_store, 1);
    chk("t2_rep1_off", rep_offset, 8);
    chk("t2_rep1_data", rep_data, 32'hDEADBEEF);
    tick();
    #1 chk("t2_rep_end", rep_valid, 0);

    // 3: full file, target limit
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 32'h3000 + 32'(i * 16), 32'h0, 5'(4 + i));
      tick();
    end
    req(1'b0, 32'h4000, 32'h0, 5'd9);
    #1 chk("t3_full", full, 1);
    chk("t3_newline_rej", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 32'h3014 + 32'(i), 32'h0, 5'(20 + i));
      #1 chk("t3_merge_ok", req_ready, 1);
      tick();
    end
    req(1'b1, 32'h3018, 32'h0, 5'd23);
    #1 chk("t3_targets_full", req_ready, 0);
    chk("t3_mem_id_low", mem_req_id, 0);
    chk("t3_mem_addr_hold", mem_req_addr, 32'h3000);
    req_valid = 1'b0; flush = 1'b1;
    #1 chk("t3_flush_withdraw", mem_req_valid, 0);
    chk("t3_flush_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    #1 chk("t3_freed", full, 0);
    chk("t3_no_issue", mem_req_valid, 0);

    // 4: out-of-order fills, replay held under backpressure
    mem_req_ready = 1'b1;
    req(1'b0, 32'h5000, 32'h0, 5'd8);
    tick();
    req(1'b0, 32'h6000, 32'h0, 5'd9);
    tick();
    req_valid = 1'b0;
    #1 chk("t4_mem_id1", mem_req_id, 1);
    chk("t4_mem_addr1", mem_req_addr, 32'h6000);
    tick();
    fill_valid = 1'b1; fill_id = 2'd1;
    tick();
    fill_id = 2'd0; rep_ready = 1'b0;
    #1 chk("t4_rep_valid", rep_valid, 1);
    chk("t4_rep_first", rep_rob, 9);
    tick();
    fill_valid = 1'b0;
    #1 chk("t4_hold1", rep_rob, 9);
    tick();
    #1 chk("t4_hold2", rep_rob, 9);
    chk("t4_hold_valid", rep_valid, 1);
    tick();
    rep_ready = 1'b1;
    #1 chk("t4_hold3", rep_rob, 9);
    tick();
    #1 chk("t4_second", rep_rob, 8);
    chk("t4_second_valid", rep_valid, 1);
    tick();
    #1 chk("t4_end", rep_valid, 0);

    // 5: flush with WAIT_ISSUE + WAIT_FILL, squashed fill
    req(1'b0, 32'h7000, 32'h0, 5'd10);
    tick();
    req(1'b0, 32'h8000, 32'h0, 5'd11);
    tick();
    mem_req_ready = 1'b0; flush = 1'b1;
    req(1'b0, 32'h9000, 32'h0, 5'd12);
    #1 chk("t5_flush_rej", req_ready, 0);
    chk("t5_withdraw", mem_req_valid, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("t5_issue_freed", mem_req_valid, 0);
    chk("t5_not_full", full, 0);
    fill_valid = 1'b1; fill_id = 2'd0;
    tick();
    fill_valid = 1'b0;
    #1 chk("t5_no_replay", rep_valid, 0);
    tick();
    #1 chk("t5_no_replay2", rep_valid, 0);
    req(1'b0, 32'h7000, 32'h0, 5'd13);
    #1 chk("t5_realloc_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1 chk("t5_realloc_id", mem_req_id, 0);
    chk("t5_realloc_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; fill_valid = 1'b1; fill_id = 2'd0;
    tick();
    fill_valid = 1'b0; rep_ready = 1'b0;
    #1 chk("t6_replaying", rep_valid, 1);
    chk("t6_rep_rob", rep_rob, 13);

    // 6: async reset mid-replay
    #1 rst_n = 1'b0;
    #1 chk("t6_rep_valid", rep_valid, 0);
    chk("t6_rep_rob0", rep_rob, 0);
    chk("t6_rep_data0", rep_data, 0);
    chk("t6_mem_valid", mem_req_valid, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_full", full, 0);
    tick();
    rst_n = 1'b1; rep_ready = 1'b1;
    #1 chk("t6_ready_after", req_ready, 1);
    chk("t6_rep_after", rep_valid, 0);
    tick();
    #1 chk("t6_still_idle", rep_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
